// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: default rates, derived widths,
// the configuration FSM encoding and the Nyquist clamp for requested frequencies.
package tick_sched_pkg;

    localparam int DEF_IN_FREQ = 100000000;
    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_ACC_W   = 40;
    localparam int DEF_FREQ_W  = 32;
    localparam int BASE        = DEF_IN_FREQ / DEF_NUM_CH;
    localparam int SLOT_W      = $clog2(DEF_NUM_CH);

    typedef enum logic {
        CFG_IDLE,
        CFG_PEND
    } cfg_state_e;

    function automatic int base_of(input int in_freq, input int num_ch);
        return in_freq / num_ch;
    endfunction

    function automatic int slot_w_of(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // A channel cannot toggle faster than half its service rate.
    function automatic logic [63:0] clamp_freq(input logic [63:0] freq, input logic [63:0] base);
        logic [63:0] lim;
        lim = base >> 1;
        return (freq > lim) ? lim : freq;
    endfunction

endpackage

// File: rtl/phase_step.sv
// Shared phase-accumulator adder: advances one channel's phase by its frequency
// and subtracts the base rate whenever the phase has wrapped non-negative.
module phase_step
    import tick_sched_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int FREQ_W = DEF_FREQ_W
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic        [FREQ_W-1:0] freq,
    input  logic signed [ACC_W-1:0]  base,
    output logic signed [ACC_W-1:0]  acc_next,
    output logic                     wrap
);

    logic signed [ACC_W-1:0] freq_ext;

    always_comb begin
        freq_ext = $signed({{(ACC_W - FREQ_W){1'b0}}, freq});
        wrap     = ~acc[ACC_W-1];
        acc_next = acc + freq_ext - (wrap ? base : '0);
    end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel fractional-rate tick generator: one phase adder shared round-robin
// across channels, reconfigured through a single-entry valid/ready write port.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int IN_FREQ = DEF_IN_FREQ,
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int FREQ_W  = DEF_FREQ_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
    input  logic [FREQ_W-1:0]          cfg_freq,
    input  logic                       cfg_en,
    input  logic                       cfg_restart,
    output logic [NUM_CH-1:0]          tick,
    output logic [NUM_CH-1:0]          level,
    output logic [$clog2(NUM_CH)-1:0]  slot
);

    localparam int SLOT_W  = slot_w_of(NUM_CH);
    localparam int CH_BASE = base_of(IN_FREQ, NUM_CH);
    localparam logic signed [ACC_W-1:0] BASE_ACC = ACC_W'(CH_BASE);

    cfg_state_e              state_q, state_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic signed [ACC_W-1:0] acc_q [NUM_CH];
    logic signed [ACC_W-1:0] acc_d [NUM_CH];
    logic [FREQ_W-1:0]       freq_q [NUM_CH];
    logic [FREQ_W-1:0]       freq_d [NUM_CH];
    logic [NUM_CH-1:0]       en_q, en_d;
    logic [NUM_CH-1:0]       tick_q, tick_d;
    logic [NUM_CH-1:0]       level_q, level_d;
    logic [SLOT_W-1:0]       pend_ch_q, pend_ch_d;
    logic [FREQ_W-1:0]       pend_freq_q, pend_freq_d;
    logic                    pend_en_q, pend_en_d;
    logic                    pend_restart_q, pend_restart_d;

    logic signed [ACC_W-1:0] svc_acc, step_acc;
    logic [FREQ_W-1:0]       svc_freq;
    logic                    step_wrap;
    logic                    apply;
    logic                    pend_ch_ok;

    assign svc_acc    = acc_q[slot_q];
    assign svc_freq   = freq_q[slot_q];
    assign pend_ch_ok = (32'(pend_ch_q) < NUM_CH);
    assign apply      = (state_q == CFG_PEND) && (pend_ch_q == slot_q);

    phase_step #(
        .ACC_W  (ACC_W),
        .FREQ_W (FREQ_W)
    ) u_phase_step (
        .acc      (svc_acc),
        .freq     (svc_freq),
        .base     (BASE_ACC),
        .acc_next (step_acc),
        .wrap     (step_wrap)
    );

    always_comb begin
        slot_d  = (slot_q == SLOT_W'(NUM_CH - 1)) ? '0 : slot_q + SLOT_W'(1);
        acc_d   = acc_q;
        freq_d  = freq_q;
        en_d    = en_q;
        tick_d  = '0;
        level_d = level_q;

        if (en_q[slot_q]) begin
            acc_d[slot_q]  = step_acc;
            tick_d[slot_q] = step_wrap;
        end

        // The new settings only take effect from the channel's next service;
        // a phase clear still overrides this service's update.
        if (apply) begin
            freq_d[slot_q] = pend_freq_q;
            en_d[slot_q]   = pend_en_q;
            if (pend_restart_q || (pend_en_q && !en_q[slot_q])) begin
                acc_d[slot_q] = '0;
            end
        end

        level_d[slot_q] = en_q[slot_q] & en_d[slot_q] & ~acc_d[slot_q][ACC_W-1];
    end

    always_comb begin
        state_d        = state_q;
        pend_ch_d      = pend_ch_q;
        pend_freq_d    = pend_freq_q;
        pend_en_d      = pend_en_q;
        pend_restart_d = pend_restart_q;

        case (state_q)
            CFG_IDLE: begin
                if (cfg_valid) begin
                    pend_ch_d      = cfg_ch;
                    pend_freq_d    = FREQ_W'(clamp_freq(64'(cfg_freq), 64'(CH_BASE)));
                    pend_en_d      = cfg_en;
                    pend_restart_d = cfg_restart;
                    state_d        = CFG_PEND;
                end
            end
            CFG_PEND: begin
                if (apply || !pend_ch_ok) begin
                    state_d = CFG_IDLE;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= CFG_IDLE;
            slot_q         <= '0;
            en_q           <= '0;
            tick_q         <= '0;
            level_q        <= '0;
            pend_ch_q      <= '0;
            pend_freq_q    <= '0;
            pend_en_q      <= 1'b0;
            pend_restart_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= '0;
                freq_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            en_q           <= en_d;
            tick_q         <= tick_d;
            level_q        <= level_d;
            pend_ch_q      <= pend_ch_d;
            pend_freq_q    <= pend_freq_d;
            pend_en_q      <= pend_en_d;
            pend_restart_q <= pend_restart_d;
            acc_q          <= acc_d;
            freq_q         <= freq_d;
        end
    end

    assign cfg_ready = (state_q == CFG_IDLE);
    assign tick      = tick_q;
    assign level     = level_q;
    assign slot      = slot_q;

endmodule
